// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON message input loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: loader state enum, rate/pad constants and a byte keep-mask helper
// used both when collecting partial words and when formatting the block.
package ascon_pkg;

    localparam int         ASCON_RATE_BYTES = 8;
    localparam logic [7:0] ASCON_PAD_BYTE   = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_OUT   = 2'd2,
        ST_SPENT = 2'd3
    } ld_state_t;

    // Ones over the first nbytes bytes of a 64-bit block (byte 0 in [63:56]).
    // Any count of a full rate or more keeps the whole block.
    function automatic logic [63:0] byte_keep_mask(input logic [3:0] nbytes);
        if (nbytes >= 4'(ASCON_RATE_BYTES)) begin
            return '1;
        end
        return ~(64'hFFFF_FFFF_FFFF_FFFF >> {nbytes, 3'b000});
    endfunction

endpackage

// File: rtl/ascon_pad_mask.sv
// Formats a raw rate block: zeroes bytes past nbytes, optionally inserts pad.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   raw_blk  in  64 : collected block, byte 0 in [63:56]
//   nbytes   in  4  : real message bytes, 0..8
//   out_blk  out 64 : masked (and, with ASCON_LOADER_PAD_EN, padded) block
// Macro ASCON_LOADER_PAD_EN: when defined, byte position nbytes carries the
// pad byte 0x80 (none when the block is full); otherwise the absorb datapath
// is expected to apply padding itself.
module ascon_pad_mask
    import ascon_pkg::*;
(
    input  logic [63:0] raw_blk,
    input  logic [3:0]  nbytes,
    output logic [63:0] out_blk
);

    logic [63:0] masked;

    assign masked = raw_blk & byte_keep_mask(nbytes);

`ifdef ASCON_LOADER_PAD_EN
    logic [63:0] pad_bits;

    always_comb begin
        pad_bits = '0;
        if (nbytes < 4'(ASCON_RATE_BYTES)) begin
            pad_bits = {ASCON_PAD_BYTE, 56'd0} >> {nbytes, 3'b000};
        end
    end

    assign out_blk = masked | pad_bits;
`else
    assign out_blk = masked;
`endif

endmodule

// File: rtl/ascon_input_loader.sv
// ASCON message loader: turns a byte length plus 32-bit host words into 64-bit rate blocks.
// Latency: blk_valid one cycle after the last needed word handshake (or after load_data_in for an empty block).
// Backpressure: s_ready held high only while FILL still needs words; the host may stall without limit.
//
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   load_length, len_in  : capture message byte length and arm the loader
//   load_data_in         : request the next rate block
//   s_data/s_valid/s_ready : host word stream, byte 0 in [31:24]
//   blk_data/blk_valid/blk_bytes/blk_last : rate block, byte 0 in [63:56]
//   busy                 : FILL or OUT in progress
//   len_err              : sticky, block requested after the final block
// Macro ASCON_LOADER_PAD_EN: insert 0x80 pad byte inside the block.
module ascon_input_loader
    import ascon_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_length,
    input  logic [LEN_W-1:0] len_in,
    input  logic             load_data_in,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [63:0]      blk_data,
    output logic             blk_valid,
    output logic [3:0]       blk_bytes,
    output logic             blk_last,
    output logic             busy,
    output logic             len_err
);

    ld_state_t        state;
    ld_state_t        state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [63:0]      buf_q;
    logic [63:0]      buf_d;
    logic [3:0]       take_q;
    logic [3:0]       take_d;
    logic [1:0]       wneed_q;
    logic [1:0]       wneed_d;
    logic [1:0]       wcnt;
    logic [3:0]       out_take;
    logic [63:0]      keep;
    logic [63:0]      blk_fmt;
    logic             start_blk;
    logic             word_hs;
    logic             last_word;

    // A same-cycle load_length wins over load_data_in.
    assign start_blk = load_data_in && !load_length && (state == ST_IDLE);
    assign word_hs   = (state == ST_FILL) && s_valid;
    assign last_word = word_hs && ((wcnt + 2'd1) == wneed_q);
    assign keep      = byte_keep_mask(take_q);

    // Bytes this block will carry, evaluated against the current remaining.
    always_comb begin
        take_d = remaining[3:0];
        if (remaining >= LEN_W'(ASCON_RATE_BYTES)) begin
            take_d = 4'(ASCON_RATE_BYTES);
        end
        if (take_d == 4'd0) begin
            wneed_d = 2'd0;
        end else if (take_d <= 4'd4) begin
            wneed_d = 2'd1;
        end else begin
            wneed_d = 2'd2;
        end
    end

    // Block buffer update; partial words are masked as they arrive.
    always_comb begin
        buf_d = buf_q;
        if (load_length || start_blk) begin
            buf_d = '0;
        end else if (word_hs) begin
            if (wcnt == 2'd0) begin
                buf_d[63:32] = s_data & keep[63:32];
            end else begin
                buf_d[31:0]  = s_data & keep[31:0];
            end
        end
    end

    // An empty block goes to OUT straight from IDLE, before take_q is loaded.
    assign out_take = start_blk ? take_d : take_q;

    ascon_pad_mask u_pad_mask (
        .raw_blk (buf_d),
        .nbytes  (out_take),
        .out_blk (blk_fmt)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_SPENT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (load_length) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_data_in) begin
                        state_nxt = (wneed_d == 2'd0) ? ST_OUT : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (last_word) begin
                        state_nxt = ST_OUT;
                    end
                end
                ST_OUT: begin
                    state_nxt = (take_q < 4'(ASCON_RATE_BYTES)) ? ST_SPENT : ST_IDLE;
                end
                default: begin
                    state_nxt = ST_SPENT;
                end
            endcase
        end
    end

    // FSM: outputs (all decoded from the state register)
    always_comb begin
        s_ready   = (state == ST_FILL);
        blk_valid = (state == ST_OUT);
        busy      = (state == ST_FILL) || (state == ST_OUT);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            remaining <= '0;
            buf_q     <= '0;
            take_q    <= '0;
            wneed_q   <= '0;
            wcnt      <= '0;
            len_err   <= 1'b0;
            blk_data  <= '0;
            blk_bytes <= '0;
            blk_last  <= 1'b0;
        end else begin
            buf_q <= buf_d;
            if (load_length) begin
                remaining <= len_in;
                wcnt      <= '0;
                len_err   <= 1'b0;
            end else begin
                if (start_blk) begin
                    take_q  <= take_d;
                    wneed_q <= wneed_d;
                    wcnt    <= '0;
                end
                if (word_hs) begin
                    wcnt <= wcnt + 2'd1;
                end
                // take never exceeds remaining, so this cannot wrap.
                if (state == ST_OUT) begin
                    remaining <= remaining - LEN_W'(take_q);
                end
                if (load_data_in && (state == ST_SPENT)) begin
                    len_err <= 1'b1;
                end
            end
            // Block outputs are loaded on entry to OUT and then held.
            if (state_nxt == ST_OUT) begin
                blk_data  <= blk_fmt;
                blk_bytes <= out_take;
                blk_last  <= (out_take < 4'(ASCON_RATE_BYTES));
            end
        end
    end

endmodule

// File: tb/tb_ascon_input_loader.sv
module tb_ascon_input_loader;

    localparam int LEN_W = 16;

    logic             clk;
    logic             rstn;
    logic             load_length;
    logic [LEN_W-1:0] len_in;
    logic             load_data_in;
    logic [31:0]      s_data;
    logic             s_valid;
    logic             s_ready;
    logic [63:0]      blk_data;
    logic             blk_valid;
    logic [3:0]       blk_bytes;
    logic             blk_last;
    logic             busy;
    logic             len_err;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  bytes;
        logic        last;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       last_exp;
    logic [7:0] msg [0:63];
    int         checks   = 0;
    int         failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ascon_input_loader #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .load_length  (load_length),
        .len_in       (len_in),
        .load_data_in (load_data_in),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .blk_data     (blk_data),
        .blk_valid    (blk_valid),
        .blk_bytes    (blk_bytes),
        .blk_last     (blk_last),
        .busy         (busy),
        .len_err      (len_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: block k of a len-byte message is bytes 8k.. of msg,
    // up to 8 of them; the rest is zero (or 0x80 then zero when padding).
    function automatic exp_t model(input int k, input int len);
        exp_t e;
        int   take;
        take = len - 8 * k;
        if (take > 8) take = 8;
        e.data = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < take)
                e.data[63-8*i -: 8] = msg[8*k+i];
`ifdef ASCON_LOADER_PAD_EN
            else if (i == take)
                e.data[63-8*i -: 8] = 8'h80;
`endif
        end
        e.bytes = 4'(take);
        e.last  = (take < 8);
        return e;
    endfunction

    function automatic logic [31:0] word_of(input int k, input int w);
        int b;
        b = 8 * k + 4 * w;
        return {msg[b], msg[b+1], msg[b+2], msg[b+3]};
    endfunction

    // Monitor: every blk_valid must match the oldest expected block; between
    // pulses the block outputs must keep the last block's values.
    always @(negedge clk) begin
        exp_t e;
        if (blk_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_blk_valid", 64'(blk_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("blk_data", blk_data, e.data);
                chk("blk_bytes", 64'(blk_bytes), 64'(e.bytes));
                chk("blk_last", 64'(blk_last), 64'(e.last));
                last_exp = e;
            end
        end else begin
            chk("hold_blk_data", blk_data, last_exp.data);
            chk("hold_blk_bytes", 64'(blk_bytes), 64'(last_exp.bytes));
            chk("hold_blk_last", 64'(blk_last), 64'(last_exp.last));
        end
    end

    task automatic pulse_len(input int len);
        load_length = 1'b1;
        len_in      = LEN_W'(len);
        @(posedge clk); #1;
        load_length = 1'b0;
    endtask

    task automatic pulse_ldi();
        load_data_in = 1'b1;
        @(posedge clk); #1;
        load_data_in = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int stall);
        int n;
        bit ok;
        s_valid = 1'b0;
        repeat (stall) begin
            s_data = $urandom;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = w;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) chk("s_ready_timeout", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = $urandom;
    endtask

    task automatic run_block(input int k, input int len, input int st0, input int st1);
        int take;
        int wn;
        take = len - 8 * k;
        if (take > 8) take = 8;
        wn = (take == 0) ? 0 : ((take <= 4) ? 1 : 2);
        pulse_ldi();
        if (wn == 0) begin
            exp_q.push_back(model(k, len));
            @(negedge clk);
            chk("empty_block_s_ready", 64'(s_ready), 64'd0);
            chk("blk_valid_latency", 64'(blk_valid), 64'd1);
        end else begin
            send_word(word_of(k, 0), st0);
            if (wn == 2) send_word(word_of(k, 1), st1);
            exp_q.push_back(model(k, len));
            @(negedge clk);
            chk("blk_valid_latency", 64'(blk_valid), 64'd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_msg(input int len, input int max_stall);
        pulse_len(len);
        for (int k = 0; k <= len / 8; k++) begin
            run_block(k, len, int'($urandom_range(0, max_stall)), int'($urandom_range(0, max_stall)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        last_exp     = '0;
        rstn         = 1'b0;
        load_length  = 1'b0;
        len_in       = '0;
        load_data_in = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_blk_valid", 64'(blk_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk("rst_blk_data", blk_data, 64'd0);
        #20;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // Out of reset the loader is spent: a request only raises len_err.
        pulse_ldi();
        @(negedge clk);
        chk("spent_after_reset_len_err", 64'(len_err), 64'd1);

        // 16-byte message, full blocks plus an empty last block.
        for (int i = 0; i < 64; i++) msg[i] = 8'(i);
        run_msg(16, 0);

        // Request after the final block.
        pulse_ldi();
        @(negedge clk);
        chk("late_req_len_err", 64'(len_err), 64'd1);
        chk("late_req_busy", 64'(busy), 64'd0);
        pulse_len(0);
        @(negedge clk);
        chk("reload_len_err_clear", 64'(len_err), 64'd0);
        chk("reload_busy", 64'(busy), 64'd0);

        // Empty message.
        run_block(0, 0, 0, 0);

        // 5-byte message; trailing bytes of the second word must vanish.
        msg[0] = 8'hAA; msg[1] = 8'hBB; msg[2] = 8'hCC; msg[3] = 8'hDD;
        msg[4] = 8'h11; msg[5] = 8'h22; msg[6] = 8'h33; msg[7] = 8'h44;
        run_msg(5, 0);

        // Host stall of 5 cycles before the second word.
        for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
        pulse_len(8);
        run_block(0, 8, 0, 5);
        run_block(1, 8, 0, 0);

        // Abort mid-FILL: the collected word is discarded.
        pulse_len(16);
        pulse_ldi();
        send_word(word_of(0, 0), 0);
        pulse_len(5);
        @(negedge clk);
        chk("abort_s_ready", 64'(s_ready), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
        run_block(0, 5, 1, 0);

        // Reset mid-FILL.
        pulse_len(16);
        pulse_ldi();
        send_word(word_of(0, 0), 0);
        #2;
        rstn     = 1'b0;
        last_exp = '0;
        #1;
        chk("midfill_rst_s_ready", 64'(s_ready), 64'd0);
        chk("midfill_rst_blk_valid", 64'(blk_valid), 64'd0);
        chk("midfill_rst_busy", 64'(busy), 64'd0);
        chk("midfill_rst_len_err", 64'(len_err), 64'd0);
        chk("midfill_rst_blk_data", blk_data, 64'd0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        pulse_ldi();
        @(negedge clk);
        chk("post_rst_needs_length", 64'(len_err), 64'd1);

        // Randomized messages with random host stalls.
        for (int m = 0; m < 20; m++) begin
            for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
            run_msg(int'($urandom_range(0, 40)), 3);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("leftover_expected_blocks", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
